// File: rtl/alu_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// alu_sequencer_pkg
//   Shared definitions for the ALU micro-sequencer:
//     - instruction opcodes (4-bit in_op encoding)
//     - ALU select codes (low three opcode bits of an ALU instruction)
//     - sequencer state encoding
//     - small opcode classification helpers
// ---------------------------------------------------------------------------
package alu_sequencer_pkg;

    // Instruction opcodes (in_op). 0xxx are ALU operations.
    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0010;
    localparam logic [3:0] OP_OR    = 4'b0011;
    localparam logic [3:0] OP_XOR   = 4'b0100;
    localparam logic [3:0] OP_SHL   = 4'b0101;
    localparam logic [3:0] OP_SHR   = 4'b0110;
    localparam logic [3:0] OP_NOT   = 4'b0111;
    localparam logic [3:0] OP_LOADI = 4'b1000;
    localparam logic [3:0] OP_NOP   = 4'b1001;

    // ALU select codes, identical to the low bits of the ALU opcodes.
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SHL = 3'b101;
    localparam logic [2:0] ALU_SHR = 3'b110;
    localparam logic [2:0] ALU_NOT = 3'b111;

    // Sequencer states. Encoding 2'b11 is unreachable and recovers to S_IDLE.
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_WB   = 2'b10
    } state_e;

    function automatic logic is_alu_op(input logic [3:0] op);
        return (op[3] == 1'b0);
    endfunction

    function automatic logic is_illegal_op(input logic [3:0] op);
        return (op[3] == 1'b1) && (op != OP_LOADI) && (op != OP_NOP);
    endfunction

endpackage

// File: rtl/alu_sequencer_alu.sv
// ---------------------------------------------------------------------------
// alu_sequencer_alu
//   Purely combinational ALU used by the sequencer.
//   Ports:
//     a, b       in   WIDTH  operands (SHL/SHR/NOT use a only)
//     alu_sel    in   3      operation select (ALU_* codes)
//     alu_out    out  WIDTH  result, wraps modulo 2^WIDTH
//     carry_out  out  1      ADD: carry out of bit WIDTH-1
//                            SUB: borrow, bit WIDTH of the WIDTH+1-bit a-b
//                            all other operations: 0
// ---------------------------------------------------------------------------
module alu_sequencer_alu
    import alu_sequencer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       alu_sel,
    output logic [WIDTH-1:0] alu_out,
    output logic             carry_out
);

    logic [WIDTH:0] wide;

    always_comb begin
        wide      = '0;
        alu_out   = '0;
        carry_out = 1'b0;
        case (alu_sel)
            ALU_ADD: begin
                wide      = {1'b0, a} + {1'b0, b};
                alu_out   = wide[WIDTH-1:0];
                carry_out = wide[WIDTH];
            end
            ALU_SUB: begin
                // Zero-extended subtraction: bit WIDTH is set exactly when b > a.
                wide      = {1'b0, a} - {1'b0, b};
                alu_out   = wide[WIDTH-1:0];
                carry_out = wide[WIDTH];
            end
            ALU_AND: alu_out = a & b;
            ALU_OR:  alu_out = a | b;
            ALU_XOR: alu_out = a ^ b;
            ALU_SHL: alu_out = a << 1;
            ALU_SHR: alu_out = a >> 1;
            ALU_NOT: alu_out = ~a;
            default: alu_out = '0;
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// ---------------------------------------------------------------------------
// alu_sequencer
//   Micro-sequencer for the mini datapath. Accepts one register-to-register
//   instruction per valid/ready handshake, reads operands from a 4-entry
//   register file, drives the shared ALU and writes the result back.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   S_IDLE | in_ready high; on in_valid latch instruction and operands
//   S_EXEC | ALU evaluates latched operands; output registered at the edge
//   S_WB   | done pulse; register-file / result / carry update at the edge
//
//   Ports:
//     clk, rst               clock, asynchronous active-high reset
//     in_valid / in_ready    instruction handshake (ready only in S_IDLE)
//     in_op, in_rd,
//     in_rs1, in_rs2, in_imm instruction fields
//     done, err              one-cycle pulses in S_WB (err for illegal op)
//     result, carry_flag     last written value / last ALU carry, held
//     dbg_sel / dbg_data     combinational register-file read port
//   NREGS is fixed at 4 (2-bit register indices).
// ---------------------------------------------------------------------------
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREGS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [1:0]       in_rd,
    input  logic [1:0]       in_rs1,
    input  logic [1:0]       in_rs2,
    input  logic [WIDTH-1:0] in_imm,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_flag,
    output logic             err,
    input  logic [1:0]       dbg_sel,
    output logic [WIDTH-1:0] dbg_data
);

    state_e           state_q,   state_d;
    logic [3:0]       op_q,      op_d;
    logic [1:0]       rd_q,      rd_d;
    logic [WIDTH-1:0] imm_q,     imm_d;
    logic [WIDTH-1:0] a_q,       a_d;
    logic [WIDTH-1:0] b_q,       b_d;
    logic [WIDTH-1:0] alu_res_q, alu_res_d;
    logic             alu_c_q,   alu_c_d;
    logic [WIDTH-1:0] result_q,  result_d;
    logic             carry_q,   carry_d;
    logic [WIDTH-1:0] regfile_q [NREGS];
    logic [WIDTH-1:0] regfile_d [NREGS];

    logic [WIDTH-1:0] alu_out;
    logic             alu_carry;

    alu_sequencer_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .a         (a_q),
        .b         (b_q),
        .alu_sel   (op_q[2:0]),
        .alu_out   (alu_out),
        .carry_out (alu_carry)
    );

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        rd_d      = rd_q;
        imm_d     = imm_q;
        a_d       = a_q;
        b_d       = b_q;
        alu_res_d = alu_res_q;
        alu_c_d   = alu_c_q;
        result_d  = result_q;
        carry_d   = carry_q;
        regfile_d = regfile_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    // Operands are captured here, so an instruction whose rd
                    // matches rs1/rs2 always sees pre-instruction values.
                    op_d    = in_op;
                    rd_d    = in_rd;
                    imm_d   = in_imm;
                    a_d     = regfile_q[in_rs1];
                    b_d     = regfile_q[in_rs2];
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_res_d = alu_out;
                alu_c_d   = alu_carry;
                state_d   = S_WB;
            end
            S_WB: begin
                state_d = S_IDLE;
                if (is_alu_op(op_q)) begin
                    regfile_d[rd_q] = alu_res_q;
                    result_d        = alu_res_q;
                    carry_d         = alu_c_q;
                end else if (op_q == OP_LOADI) begin
                    regfile_d[rd_q] = imm_q;
                    result_d        = imm_q;
                end
                // NOP and illegal opcodes leave all architectural state alone.
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            op_q      <= OP_NOP;
            rd_q      <= '0;
            imm_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_res_q <= '0;
            alu_c_q   <= 1'b0;
            result_q  <= '0;
            carry_q   <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                regfile_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            rd_q      <= rd_d;
            imm_q     <= imm_d;
            a_q       <= a_d;
            b_q       <= b_d;
            alu_res_q <= alu_res_d;
            alu_c_q   <= alu_c_d;
            result_q  <= result_d;
            carry_q   <= carry_d;
            regfile_q <= regfile_d;
        end
    end

    // in_ready is gated by rst so it drops the moment reset is asserted.
    assign in_ready   = (state_q == S_IDLE) && !rst;
    assign done       = (state_q == S_WB);
    assign err        = (state_q == S_WB) && is_illegal_op(op_q);
    assign result     = result_q;
    assign carry_flag = carry_q;
    assign dbg_data   = regfile_q[dbg_sel];

endmodule

// File: tb/tb_alu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_sequencer
//   Self-checking bench for alu_sequencer (WIDTH=8). A vector table holds
//   instructions with hand-computed results; accepted instructions push their
//   expectations to a scoreboard queue that a monitor pops on each done pulse.
//   Hand-written sequences cover back-to-back throughput and mid-flight reset.
// ---------------------------------------------------------------------------
module tb_alu_sequencer;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [3:0]       in_op = 4'h9;
    logic [1:0]       in_rd = '0;
    logic [1:0]       in_rs1 = '0;
    logic [1:0]       in_rs2 = '0;
    logic [WIDTH-1:0] in_imm = '0;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry_flag;
    logic             err;
    logic [1:0]       dbg_sel = '0;
    logic [WIDTH-1:0] dbg_data;

    alu_sequencer #(.WIDTH(WIDTH), .NREGS(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_imm     (in_imm),
        .done       (done),
        .result     (result),
        .carry_flag (carry_flag),
        .err        (err),
        .dbg_sel    (dbg_sel),
        .dbg_data   (dbg_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0]       op;
        logic [1:0]       rd;
        logic [1:0]       rs1;
        logic [1:0]       rs2;
        logic [WIDTH-1:0] imm;
        logic [WIDTH-1:0] exp_res;
        logic             exp_c;
        logic             exp_err;
        logic [WIDTH-1:0] exp_dbg;   // register rd after the instruction
    } vec_t;

    typedef struct {
        logic [WIDTH-1:0] res;
        logic             c;
        logic             e;
        int               acc_cyc;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_done   = 0;
    int   last_acc = 0;
    bit   have_pend = 0;
    exp_t pend;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                                input logic [1:0] rs2, input logic [7:0] imm, input logic [7:0] er,
                                input logic ec, input logic ee, input logic [7:0] ed);
        vec_t v;
        v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm;
        v.exp_res = er; v.exp_c = ec; v.exp_err = ee; v.exp_dbg = ed;
        return v;
    endfunction

    // Called at posedge+1. Holds the instruction until accepted, then returns
    // at posedge+1 after the accepting edge with in_valid still high.
    task automatic issue(input vec_t v);
        int   cnt;
        exp_t e;
        in_valid = 1'b1;
        in_op = v.op; in_rd = v.rd; in_rs1 = v.rs1; in_rs2 = v.rs2; in_imm = v.imm;
        cnt = 0;
        while (!in_ready && cnt < 50) begin
            @(posedge clk); #1;
            cnt++;
        end
        if (cnt >= 50) begin
            chk("accept_timeout", 32'd1, 32'd0);
        end else begin
            e.res = v.exp_res; e.c = v.exp_c; e.e = v.exp_err; e.acc_cyc = cyc;
            last_acc = cyc;
            @(posedge clk); #1;
            sb_q.push_back(e);
        end
    endtask

    task automatic wait_idle();
        int cnt;
        cnt = 0;
        while ((sb_q.size() != 0 || have_pend) && cnt < 40) begin
            @(posedge clk); #1;
            cnt++;
        end
        if (cnt >= 40) chk("drain_timeout", 32'd1, 32'd0);
    endtask

    // Scoreboard monitor: err is compared with done, result/carry one cycle
    // later once the write-back edge has happened.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                have_pend = 0;
            end else begin
                if (have_pend) begin
                    chk("result", result, pend.res);
                    chk("carry_flag", carry_flag, pend.c);
                    chk("done_one_cycle", done, 1'b0);
                    have_pend = 0;
                end else if (done) begin
                    n_done++;
                    if (sb_q.size() == 0) begin
                        chk("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        pend = sb_q.pop_front();
                        chk("err", err, pend.e);
                        chk("latency", cyc - pend.acc_cyc, 32'd2);
                        have_pend = 1;
                    end
                end else if (err) begin
                    chk("err_without_done", err, 1'b0);
                end
            end
        end
    end

    vec_t vecs[17];
    int   acc[4];
    int   d0;

    initial begin
        vecs[0]  = mk(4'h8, 2'd1, 2'd0, 2'd0, 8'hF0, 8'hF0, 1'b0, 1'b0, 8'hF0); // LOADI r1
        vecs[1]  = mk(4'h8, 2'd2, 2'd0, 2'd0, 8'h20, 8'h20, 1'b0, 1'b0, 8'h20); // LOADI r2
        vecs[2]  = mk(4'h0, 2'd3, 2'd1, 2'd2, 8'h00, 8'h10, 1'b1, 1'b0, 8'h10); // ADD wraps
        vecs[3]  = mk(4'h1, 2'd0, 2'd2, 2'd1, 8'h00, 8'h30, 1'b1, 1'b0, 8'h30); // SUB borrow
        vecs[4]  = mk(4'h1, 2'd0, 2'd1, 2'd2, 8'h00, 8'hD0, 1'b0, 1'b0, 8'hD0); // SUB
        vecs[5]  = mk(4'h5, 2'd3, 2'd1, 2'd0, 8'h00, 8'hE0, 1'b0, 1'b0, 8'hE0); // SHL
        vecs[6]  = mk(4'h7, 2'd3, 2'd2, 2'd0, 8'h00, 8'hDF, 1'b0, 1'b0, 8'hDF); // NOT
        vecs[7]  = mk(4'h2, 2'd3, 2'd1, 2'd2, 8'h00, 8'h20, 1'b0, 1'b0, 8'h20); // AND
        vecs[8]  = mk(4'h3, 2'd3, 2'd1, 2'd2, 8'h00, 8'hF0, 1'b0, 1'b0, 8'hF0); // OR
        vecs[9]  = mk(4'h4, 2'd3, 2'd1, 2'd2, 8'h00, 8'hD0, 1'b0, 1'b0, 8'hD0); // XOR
        vecs[10] = mk(4'h6, 2'd3, 2'd1, 2'd0, 8'h00, 8'h78, 1'b0, 1'b0, 8'h78); // SHR
        vecs[11] = mk(4'h0, 2'd3, 2'd1, 2'd2, 8'h00, 8'h10, 1'b1, 1'b0, 8'h10); // ADD sets carry
        vecs[12] = mk(4'hC, 2'd2, 2'd0, 2'd0, 8'h55, 8'h10, 1'b1, 1'b1, 8'h20); // illegal
        vecs[13] = mk(4'h9, 2'd1, 2'd0, 2'd0, 8'h66, 8'h10, 1'b1, 1'b0, 8'hF0); // NOP
        vecs[14] = mk(4'h8, 2'd0, 2'd0, 2'd0, 8'hAA, 8'hAA, 1'b1, 1'b0, 8'hAA); // LOADI keeps carry
        vecs[15] = mk(4'h0, 2'd0, 2'd0, 2'd0, 8'h00, 8'h54, 1'b1, 1'b0, 8'h54); // rd==rs hazard
        vecs[16] = mk(4'h1, 2'd3, 2'd3, 2'd3, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00); // SUB equal

        // Reset state
        #1;
        chk("in_ready_in_reset", in_ready, 1'b0);
        chk("done_in_reset", done, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("in_ready_after_reset", in_ready, 1'b1);
        chk("result_reset", result, 8'h00);
        chk("carry_reset", carry_flag, 1'b0);
        chk("err_reset", err, 1'b0);
        for (int i = 0; i < 4; i++) begin
            dbg_sel = i[1:0]; #1;
            chk("regfile_reset", dbg_data, 8'h00);
        end

        // Table-driven instructions, one at a time
        for (int i = 0; i < 17; i++) begin
            issue(vecs[i]);
            in_valid = 1'b0;
            chk("in_ready_busy", in_ready, 1'b0);
            wait_idle();
            dbg_sel = vecs[i].rd; #1;
            chk("dbg_rd", dbg_data, vecs[i].exp_dbg);
        end
        dbg_sel = 2'd0; #1; chk("final_r0", dbg_data, 8'h54);
        dbg_sel = 2'd1; #1; chk("final_r1", dbg_data, 8'hF0);
        dbg_sel = 2'd2; #1; chk("final_r2", dbg_data, 8'h20);
        dbg_sel = 2'd3; #1; chk("final_r3", dbg_data, 8'h00);

        // Back-to-back: in_valid held high across 4 dependent instructions
        d0 = n_done;
        issue(mk(4'h8, 2'd0, 2'd0, 2'd0, 8'h01, 8'h01, 1'b0, 1'b0, 8'h01)); acc[0] = last_acc;
        issue(mk(4'h8, 2'd1, 2'd0, 2'd0, 8'h02, 8'h02, 1'b0, 1'b0, 8'h02)); acc[1] = last_acc;
        issue(mk(4'h0, 2'd2, 2'd0, 2'd1, 8'h00, 8'h03, 1'b0, 1'b0, 8'h03)); acc[2] = last_acc;
        issue(mk(4'h1, 2'd3, 2'd0, 2'd1, 8'h00, 8'hFF, 1'b1, 1'b0, 8'hFF)); acc[3] = last_acc;
        in_valid = 1'b0;
        for (int i = 1; i < 4; i++) chk("accept_gap", acc[i] - acc[i-1], 32'd3);
        wait_idle();
        chk("b2b_done_count", n_done - d0, 32'd4);
        dbg_sel = 2'd2; #1; chk("b2b_r2", dbg_data, 8'h03);
        dbg_sel = 2'd3; #1; chk("b2b_r3", dbg_data, 8'hFF);

        // Reset in the middle of EXEC: in-flight ADD is discarded
        issue(mk(4'h0, 2'd0, 2'd0, 2'd1, 8'h00, 8'h03, 1'b0, 1'b0, 8'h03));
        #2 rst = 1'b1;
        #1;
        sb_q.delete();
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_result", result, 8'h00);
        chk("rst_carry", carry_flag, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        for (int i = 0; i < 4; i++) begin
            dbg_sel = i[1:0]; #1;
            chk("rst_regfile", dbg_data, 8'h00);
        end
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        d0 = n_done;
        repeat (6) @(posedge clk);
        #1;
        chk("no_done_after_reset", n_done - d0, 32'd0);
        chk("in_ready_after_release", in_ready, 1'b1);

        // Recovery after reset; r0 must read as cleared
        issue(mk(4'h8, 2'd2, 2'd0, 2'd0, 8'h5A, 8'h5A, 1'b0, 1'b0, 8'h5A));
        in_valid = 1'b0;
        wait_idle();
        issue(mk(4'h0, 2'd3, 2'd2, 2'd0, 8'h00, 8'h5A, 1'b0, 1'b0, 8'h5A));
        in_valid = 1'b0;
        wait_idle();
        dbg_sel = 2'd3; #1; chk("recover_r3", dbg_data, 8'h5A);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
